// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the request/response handshake and the SRAM port of the data-memory
// access unit.
//   slave  modport : the access unit itself (takes requests, drives the SRAM)
//   master modport : the environment (request producer plus SRAM)
// Signals:
//   req_valid/req_ready/req_addr/req_wdata/req_mode : request handshake
//   resp_valid/resp_rdata/resp_err                  : single-cycle response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata      : synchronous SRAM port
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [2:0]            req_mode;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_mode, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_mode, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access unit between the execute stage and a word-wide
// single-port synchronous SRAM. Handles one load/store at a time: byte/half/
// word loads with sign or zero extension, sub-word stores by read-modify-write,
// and misalignment detection. Every output is a register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_access_unit_if.slave (request, response and SRAM signals)
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd3;
  localparam logic [2:0] M_LHU = 3'd4;
  localparam logic [2:0] M_SB  = 3'd5;
  localparam logic [2:0] M_SH  = 3'd6;
  localparam logic [2:0] M_SW  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_RWAIT = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic misaligned(input logic [2:0] mode, input logic [1:0] lo);
    logic r;
    case (mode)
      M_LH, M_LHU, M_SH: r = lo[0];
      M_LW, M_SW:        r = (lo != 2'd0);
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

  // Select the addressed little-endian lane and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  mode,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (mode)
      M_LB:    r = {{24{b[7]}}, b};
      M_LBU:   r = {24'd0, b};
      M_LH:    r = {{16{h[15]}}, h};
      M_LHU:   r = {16'd0, h};
      M_LW:    r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the read word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wdata,
                                              input logic [2:0]  mode,
                                              input logic [1:0]  lo);
    logic [31:0] r;
    r = word;
    case (mode)
      M_SB: r[{lo, 3'b000} +: 8] = wdata[7:0];
      M_SH: begin
        if (lo[1]) r[31:16] = wdata;
        else       r[15:0]  = wdata;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  state_t                state_q;
  logic [2:0]            mode_q;
  logic [1:0]            addr_lo_q;
  logic [15:0]           wdata_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [MEM_AW-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // Access sequencer: strobes and response are set on the transition into the
  // state that presents them, so every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 3'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= 16'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // req_ready is raised here after reset, so accepts start one cycle later.
          req_ready_q <= 1'b1;
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            mode_q      <= bus.req_mode;
            addr_lo_q   <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata[15:0];
            // Upper address bits are dropped: accesses wrap modulo SRAM size.
            mem_addr_q  <= bus.req_addr[MEM_AW+1:2];
            if (misaligned(bus.req_mode, bus.req_addr[1:0])) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.req_mode == M_SW) begin
              state_q     <= S_WRITE;
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q  <= S_READ;
              mem_en_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q <= S_RWAIT;
        end
        S_RWAIT: begin
          // SRAM read data is valid in this cycle.
          if (mode_q == M_SB || mode_q == M_SH) begin
            state_q     <= S_WRITE;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= store_merge(bus.mem_rdata, wdata_q, mode_q, addr_lo_q);
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_extract(bus.mem_rdata, mode_q, addr_lo_q);
          end
        end
        S_WRITE: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: directed test-plan scenarios plus
// randomized requests checked against a word-array reference model.
module tb_mem_access_unit;

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd3;
  localparam logic [2:0] M_LHU = 3'd4;
  localparam logic [2:0] M_SB  = 3'd5;
  localparam logic [2:0] M_SH  = 3'd6;
  localparam logic [2:0] M_SW  = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [31:0] sram [0:65535];
  logic [31:0] refm [0:65535];

  mem_access_unit_if #(.DATA_WIDTH(32), .MEM_AW(16)) bus ();

  mem_access_unit #(.DATA_WIDTH(32), .MEM_AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous single-port SRAM
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[17:2]);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    sram[widx(a)] = w;
    refm[widx(a)] = w;
  endtask

  // Reference model: applies one request to refm, returns expected response.
  function automatic void model(input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] wd, output int lat,
                                output logic [31:0] rd, output logic e);
    int          w;
    int          sh;
    logic [31:0] word;
    w    = widx(a);
    word = refm[w];
    sh   = 8 * int'(a[1:0]);
    e    = ((m == M_LH || m == M_LHU || m == M_SH) && a[0]) ||
           ((m == M_LW || m == M_SW) && a[1:0] != 2'd0);
    rd   = 32'd0;
    lat  = 1;
    if (!e) begin
      case (m)
        M_LB: begin
          rd = (word >> sh) & 32'hFF;
          if (rd >= 32'd128) rd = rd - 32'd256;
          lat = 3;
        end
        M_LBU: begin rd = (word >> sh) & 32'hFF; lat = 3; end
        M_LH: begin
          rd = (word >> (16 * int'(a[1]))) & 32'hFFFF;
          if (rd >= 32'd32768) rd = rd - 32'd65536;
          lat = 3;
        end
        M_LHU: begin rd = (word >> (16 * int'(a[1]))) & 32'hFFFF; lat = 3; end
        M_LW: begin rd = word; lat = 3; end
        M_SB: begin
          refm[w] = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          lat = 4;
        end
        M_SH: begin
          sh = 16 * int'(a[1]);
          refm[w] = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
          lat = 4;
        end
        M_SW: begin refm[w] = wd; lat = 2; end
        default: lat = 1;
      endcase
    end
  endfunction

  // Issue one request and observe it for 8 cycles after the accept edge.
  task automatic do_req(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic e,
                        output int rd_at, output int wr_at, output int n_en,
                        output int n_resp, output logic [31:0] wr_word,
                        output logic [15:0] st_addr);
    int g;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    lat = -1; rd = 32'hX; e = 1'bX; rd_at = -1; wr_at = -1;
    n_en = 0; n_resp = 0; wr_word = 32'd0; st_addr = 16'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.mem_en) begin
        n_en++;
        st_addr = bus.mem_addr;
        if (bus.mem_we) begin wr_at = k; wr_word = bus.mem_wdata; end
        else rd_at = k;
      end
      if (bus.resp_valid) begin
        n_resp++;
        if (lat < 0) begin lat = k; rd = bus.resp_rdata; e = bus.resp_err; end
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_en, bus.mem_we} !== 5'd0 ||
        bus.resp_rdata !== 32'd0 || bus.mem_addr !== 16'd0 || bus.mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b err=%b en=%b we=%b rdata=%h addr=%h wdata=%h, required all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_en, bus.mem_we,
               bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early: got %b required 0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_lw;
    int lat, ra, wa, ne, nr; logic [31:0] rd, ww; logic e; logic [15:0] sa;
    preload(32'h40, 32'hDEADBEEF);
    do_req(M_LW, 32'h40, 32'd0, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat != 3 || ne != 1 || ra != 1 || sa !== 16'h10) begin
      failures++;
      $display("FAIL lw_basic: rdata=%h err=%b lat=%0d en=%0d rd_at=%0d addr=%h, required DEADBEEF 0 3 1 1 0010",
               rd, e, lat, ne, ra, sa);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  modes [4] = '{M_LB, M_LBU, M_LH, M_LHU};
    logic [31:0] addrs [4] = '{32'h11, 32'h11, 32'h10, 32'h10};
    logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
    int lat, ra, wa, ne, nr; logic [31:0] rd, ww; logic e; logic [15:0] sa;
    preload(32'h10, 32'h00008000);
    for (int i = 0; i < 4; i++) begin
      do_req(modes[i], addrs[i], 32'd0, lat, rd, e, ra, wa, ne, nr, ww, sa);
      checks++;
      if (rd !== exps[i] || e !== 1'b0 || lat != 3) begin
        failures++;
        $display("FAIL load_ext[%0d]: rdata=%h err=%b lat=%0d, required %h 0 3", i, rd, e, lat, exps[i]);
      end
    end
  endtask

  task automatic test_store_sub;
    int lat, ra, wa, ne, nr; logic [31:0] rd, ww; logic e; logic [15:0] sa;
    preload(32'h20, 32'h11223344);
    do_req(M_SB, 32'h22, 32'h000000AB, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (ra != 1 || wa != 3 || ww !== 32'h11AB3344 || lat != 4 || e !== 1'b0 || rd !== 32'd0) begin
      failures++;
      $display("FAIL sb_rmw: rd_at=%0d wr_at=%0d wdata=%h lat=%0d err=%b rdata=%h, required 1 3 11AB3344 4 0 0",
               ra, wa, ww, lat, e, rd);
    end
    do_req(M_LW, 32'h20, 32'd0, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (rd !== 32'h11AB3344) begin
      failures++;
      $display("FAIL sb_readback: got %h required 11AB3344", rd);
    end
    preload(32'h24, 32'h11223344);
    do_req(M_SH, 32'h26, 32'h00005566, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (sram[widx(32'h24)] !== 32'h55663344 || lat != 4) begin
      failures++;
      $display("FAIL sh_merge: mem=%h lat=%0d required 55663344 4", sram[widx(32'h24)], lat);
    end
    do_req(M_SW, 32'h20, 32'hCAFEF00D, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (ne != 1 || wa != 1 || ra != -1 || lat != 2 || sram[widx(32'h20)] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL sw_direct: en=%0d wr_at=%0d rd_at=%0d lat=%0d mem=%h, required 1 1 -1 2 CAFEF00D",
               ne, wa, ra, lat, sram[widx(32'h20)]);
    end
  endtask

  task automatic test_misaligned;
    int lat, ra, wa, ne, nr; logic [31:0] rd, ww; logic e; logic [15:0] sa;
    do_req(M_LW, 32'h42, 32'd0, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (lat != 1 || e !== 1'b1 || rd !== 32'd0 || ne != 0) begin
      failures++;
      $display("FAIL lw_misaligned: lat=%0d err=%b rdata=%h en=%0d, required 1 1 0 0", lat, e, rd, ne);
    end
    preload(32'h20, 32'h11223344);
    do_req(M_SH, 32'h21, 32'h0000BEEF, lat, rd, e, ra, wa, ne, nr, ww, sa);
    checks++;
    if (lat != 1 || e !== 1'b1 || ne != 0 || sram[widx(32'h20)] !== 32'h11223344) begin
      failures++;
      $display("FAIL sh_misaligned: lat=%0d err=%b en=%0d mem=%h, required 1 1 0 11223344",
               lat, e, ne, sram[widx(32'h20)]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3] = '{32'h100, 32'h104, 32'h108};
    int acc [$];
    logic [31:0] got [$];
    int n = 0;
    int g = 0;
    int bad_ready = 0;
    bit accepting;
    for (int i = 0; i < 3; i++) preload(addrs[i], $urandom);
    while (got.size() < 3 && g < 40) begin
      @(negedge clk);
      g++;
      if (bus.resp_valid) got.push_back(bus.resp_rdata);
      bus.req_valid = (n < 3);
      bus.req_mode  = M_LW;
      bus.req_addr  = addrs[(n < 3) ? n : 2];
      accepting = 1'b0;
      if (bus.req_ready && n < 3) begin
        acc.push_back(cyc);
        n++;
        accepting = 1'b1;
      end
      if (acc.size() > 0 && n < 3 && !accepting && bus.req_ready) bad_ready++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (acc.size() != 3 || acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4 || bad_ready != 0) begin
      failures++;
      $display("FAIL b2b_spacing: accepts=%0d gaps=%0d,%0d ready_while_busy=%0d, required 3 4,4 0",
               acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1,
               (acc.size() > 2) ? acc[2] - acc[1] : -1, bad_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== refm[widx(addrs[i])]) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got %h required %h", i,
                 (got.size() > i) ? got[i] : 32'hX, refm[widx(addrs[i])]);
      end
    end
  endtask

  task automatic test_random;
    int lat, ra, wa, ne, nr, elat, erd_at, ewr_at;
    logic [31:0] rd, ww, erd, a, wd;
    logic e, ee;
    logic [15:0] sa;
    logic [2:0] m;
    for (int i = 0; i < 60; i++) begin
      m  = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFC_0000) | 32'h800 | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
      wd = $urandom;
      model(m, a, wd, elat, erd, ee);
      erd_at = (ee || m == M_SW) ? -1 : 1;
      ewr_at = ee ? -1 : (m == M_SW) ? 1 : (m == M_SB || m == M_SH) ? 3 : -1;
      do_req(m, a, wd, lat, rd, e, ra, wa, ne, nr, ww, sa);
      checks++;
      if (lat != elat || rd !== erd || e !== ee || nr != 1 || ra != erd_at || wa != ewr_at ||
          (ne > 0 && sa !== a[17:2]) || sram[widx(a)] !== refm[widx(a)]) begin
        failures++;
        $display("FAIL random[%0d] mode=%0d addr=%h: lat=%0d rdata=%h err=%b nresp=%0d rd_at=%0d wr_at=%0d maddr=%h mem=%h, required %0d %h %b 1 %0d %0d %h %h",
                 i, m, a, lat, rd, e, nr, ra, wa, sa, sram[widx(a)],
                 elat, erd, ee, erd_at, ewr_at, a[17:2], refm[widx(a)]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int g;
    int bad = 0;
    preload(32'h80, 32'h01020304);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mode  = M_SB;
    bus.req_addr  = 32'h81;
    bus.req_wdata = 32'h000000EE;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_en, bus.mem_we} !== 5'd0 ||
          bus.resp_rdata !== 32'd0 || bus.mem_addr !== 16'd0 || bus.mem_wdata !== 32'd0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_outputs_zero: %0d nonzero samples, required 0", bad);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready: got %b required 1", bus.req_ready);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.resp_valid || bus.mem_en) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || sram[widx(32'h80)] !== 32'h01020304) begin
      failures++;
      $display("FAIL abort_no_write: activity=%0d mem=%h, required 0 01020304", bad, sram[widx(32'h80)]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 32'h0;
      refm[i] = 32'h0;
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_mode  = 3'd0;
    bus.mem_rdata = 32'd0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store_sub();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
